// File: rtl/shift_pkg.sv
// Shared definitions for the shift datapath: op encodings, default widths and
// the result-slot state type used by shift_arbiter.
package shift_pkg;

  localparam int SH_DW = 32;
  localparam int SH_AW = 5;

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  typedef logic [0:0] state_t;
  localparam state_t EMPTY = 1'b0;
  localparam state_t FULL  = 1'b1;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational barrel shifter: logical left/right, arithmetic right and
// rotate right, with the op codes bound by the instantiating module.
module barrel_shifter #(
  parameter int         DW   = 32,
  parameter int         AW   = 5,
  parameter logic [1:0] lo_l = 2'd0,
  parameter logic [1:0] lo_r = 2'd1,
  parameter logic [1:0] al_r = 2'd2,
  parameter logic [1:0] ci_r = 2'd3
) (
  input  logic [DW-1:0] data,
  input  logic [AW-1:0] amt,
  input  logic [1:0]    op,
  output logic [DW-1:0] result
);

  logic [2*DW-1:0] rot;

  assign rot = {data, data} >> amt;

  // NOTE: result gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    result = data;
    case (op)
      lo_l:    result = data << amt;
      lo_r:    result = data >> amt;
      al_r:    result = $signed(data) >>> amt;
      ci_r:    result = rot[DW-1:0];
      default: result = data;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel_shifter between two requesters, with a
// single registered result slot. Define SHIFT_ARB_PERF_EN to add perf counters.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int DW = SH_DW,
  parameter int AW = SH_AW,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_data,
  input  logic [AW-1:0] req0_amt,
  input  logic [1:0]    req0_op,
  input  logic [TW-1:0] req0_tag,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_data,
  input  logic [AW-1:0] req1_amt,
  input  logic [1:0]    req1_op,
  input  logic [TW-1:0] req1_tag,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [TW-1:0] res_tag,
  output logic          res_src
`ifdef SHIFT_ARB_PERF_EN
  ,
  input  logic          perf_clr,
  output logic [31:0]   perf_grant0,
  output logic [31:0]   perf_grant1,
  output logic [31:0]   perf_stall
`endif
);

  state_t        state;
  logic          last_grant;
  logic          can_accept;
  logic          acc0, acc1, accept;
  logic [DW-1:0] sel_data, sh_out;
  logic [AW-1:0] sel_amt;
  logic [1:0]    sel_op;

  assign can_accept = (state == EMPTY) | res_ready;

  // Each ready looks only at the other port's valid, so a requester's ready never
  // depends on its own valid; the round-robin tie-break still admits one accept.
  assign req0_ready = can_accept & (~req1_valid | last_grant);
  assign req1_ready = can_accept & (~req0_valid | ~last_grant);

  assign acc0   = req0_valid & req0_ready;
  assign acc1   = req1_valid & req1_ready;
  assign accept = acc0 | acc1;

  assign sel_data = acc1 ? req1_data : req0_data;
  assign sel_amt  = acc1 ? req1_amt  : req0_amt;
  assign sel_op   = acc1 ? req1_op   : req0_op;

  barrel_shifter #(
    .DW   (DW),
    .AW   (AW),
    .lo_l (SH_LSL),
    .lo_r (SH_LSR),
    .al_r (SH_ASR),
    .ci_r (SH_ROR)
  ) u_shifter (
    .data   (sel_data),
    .amt    (sel_amt),
    .op     (sel_op),
    .result (sh_out)
  );

  assign res_valid = (state == FULL);

  // NOTE: state is updated with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
      res_data   <= '0;
      res_tag    <= '0;
      res_src    <= 1'b0;
    end else if (accept) begin
      state      <= FULL;
      last_grant <= acc1;
      res_data   <= sh_out;
      res_tag    <= acc1 ? req1_tag : req0_tag;
      res_src    <= acc1;
    end else if ((state == FULL) && res_ready) begin
      state <= EMPTY;
    end
  end

`ifdef SHIFT_ARB_PERF_EN
  logic stall;

  assign stall = (req0_valid | req1_valid) & ~accept;

  // A clear in the same cycle as an increment takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall  <= '0;
    end else if (perf_clr) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall  <= '0;
    end else begin
      perf_grant0 <= perf_grant0 + 32'(acc0);
      perf_grant1 <= perf_grant1 + 32'(acc1);
      perf_stall  <= perf_stall + 32'(stall);
    end
  end
`endif

endmodule
